decrypt_iter: RTL
=================

Name: decrypt_iter

Overview:
Iterative DES decryption engine: the inverse of encrypt_iter. It accepts a 64-bit key and a 64-bit ciphertext under a req/ack handshake. It runs the 16 Feistel rounds one per clock, with round keys generated on the fly in reverse order, and returns the 64-bit plaintext. It reuses the existing perm_IP, perm_PC1, split_2, round, merge_2 and perm_FP blocks. Only the key schedule direction and the control differ from encryption.

Parameters:
N_K, 64, key width in bits (from params.h)
N_B, 64, block width in bits (from params.h)
N_R, 16, number of DES rounds (from params.h)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low
k  input  N_K  cipher key; sampled only at load
c  input  N_B  ciphertext; sampled only at load
m  output  N_B  recovered plaintext; valid while ack=1
req  input  1  request; held high by requester until ack seen
ack  output  1  acknowledge; high while m valid and req still high

Behaviour:
- Reset: rst=0 at a rising edge forces state=IDLE, rnd=0, ack=0, m=0, and clears the L/R and C/D registers. Reset takes priority over everything, including mid-run.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - ack=0.
  - On an edge with req=1, latch L/R = split_2(perm_IP(c)) and CD = perm_PC1(k) (56 bits), set rnd=0, go to RUN.
- RUN:
  - Each edge applies one round: (L,R) <= round(L, R, K_rnd), with CD updated to the next value and rnd <= rnd+1.
  - Round key K_rnd = PC2(rotr(CD, s[rnd])). The 28-bit C and D halves are rotated right independently.
  - Right-rotation schedule s = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Key order is therefore K16..K1; no precomputation pass is needed.
  - The rnd=15 edge (i.e. rnd == N_R-1) also registers m = perm_FP(merge_2(R16, L16)), i.e. with the final swap, sets ack=1, and goes to DONE.
  - If req=0 at any RUN edge: abort to IDLE, ack stays 0, m unchanged.
- DONE:
  - ack=1 and m held stable.
  - On an edge with req=0, ack<=0 and go to IDLE.
  - m holds its value until the next completion or reset.
- Latency: load at edge T, rounds at edges T+1..T+16, ack high after edge T+16. The requester therefore sees ack 17 edges after first asserting req.
- k and c are ignored after the load edge; changing them mid-run has no effect.
- Back-to-back operation: req must drop for at least one edge (DONE->IDLE) before the next load. The minimum period is 18 edges per block.
- rnd is 5 bits wide and never exceeds 15 in RUN, so there is no wrap.
- m is undefined-by-contract when ack=0, but the implementation holds the last value (reset value 0).

Decomposition:
- params.h: N_K, N_B, N_R, plus new constants for the decrypt rotation schedule (per-round shift amount 0/1/2) and state encodings for IDLE/RUN/DONE.
- The PC2 and rotation helpers already used by key_schedule are shared, not duplicated.
- One new sub-module, key_schedule_inv:
  - Ports mirror key_schedule: x[55:0] current CD, i[4:0] round index, r[55:0] next CD, k[47:0] round key.
  - It rotates right by s[i].
- The top level holds only the FSM, the datapath registers and the existing permutation and round instances.

Test Plan:
- Textbook vector: k=133457799BBCDFF1, c=85E813540F0AB405, req held high -> ack rises after edge 17; m=0123456789ABCDEF.
- Second vector: k=0E329232EA6D0D73, c=0000000000000000 -> m=8787878787878787. All-zero key, c=8CA64DE9C1B123A7 -> m=0000000000000000.
- Round trip: encrypt_iter(k, random m), then decrypt_iter(k, result), for 200 random k/m pairs -> output equals original m.
- Handshake:
  - After ack, hold req high 5 extra cycles -> ack and m stable.
  - Drop req -> ack=0 on next edge.
  - Reassert req with a new c -> new result after 17 edges.
- Abort and input-change:
  - Drop req at round 7 -> returns to IDLE, ack never rises, m keeps its previous value.
  - Change k and c during RUN -> result is unaffected.
- Reset: drive rst=0 during round 10 -> next edge ack=0, m=0, FSM idle. A new request then completes correctly with the textbook vector.

Source files
------------

// File: rtl/decrypt_iter_pkg.sv
// decrypt_iter_pkg: shared constants, state encoding and DES helper functions.
// Holds the DES permutation tables, S-boxes, the decrypt rotation schedule
// and the combinational building blocks (IP, FP, PC1, PC2, rotation, round).
// Table entries use DES numbering: bit 1 is the MSB of the vector.
package decrypt_iter_pkg;

  localparam int N_K = 64;
  localparam int N_B = 64;
  localparam int N_R = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-rotation amount per decrypt round; undoes the encrypt left shifts
  // in reverse order, starting from C16D16 (equal to C0D0).
  localparam logic [1:0] ROTR_SCHED [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each S-box is 64 nibbles, row-major (row*16 + col), first entry in the MSBs.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [1:0] rotr_amount(input logic [4:0] rnd);
    return rnd[4] ? 2'd0 : ROTR_SCHED[rnd[3:0]];
  endfunction

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [55:0] xx;
    xx = {x, x};
    return xx[n +: 28];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    // Outer bits of each 6-bit group pick the row, inner four the column.
    for (int j = 0; j < 8; j++) begin
      b = e[47-6*j -: 6];
      s[31-4*j -: 4] = SBOX[j][255 - 4*int'({b[5], b[0], b[4:1]}) -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  // One Feistel round: returns {L', R'} = {R, L ^ f(R, K)}.
  function automatic logic [63:0] des_round(input logic [31:0] l, input logic [31:0] r,
                                            input logic [47:0] k);
    return {r, l ^ feistel(r, k)};
  endfunction

endpackage

// File: rtl/decrypt_iter_if.sv
// decrypt_iter_if: request/acknowledge bus of the DES decryption engine.
//   k   : cipher key (requester -> engine)
//   c   : ciphertext (requester -> engine)
//   req : request, held until ack is seen
//   m   : recovered plaintext (engine -> requester)
//   ack : result valid while req still high
interface decrypt_iter_if;
  import decrypt_iter_pkg::*;

  logic [N_K-1:0] k;
  logic [N_B-1:0] c;
  logic           req;
  logic [N_B-1:0] m;
  logic           ack;

  modport master (output k, c, req, input m, ack);
  modport slave  (input k, c, req, output m, ack);
endinterface

// File: rtl/decrypt_iter_key_schedule_inv.sv
// key_schedule_inv: reverse-order DES key schedule step.
//   x : current C/D register (56 bits)
//   i : round index 0..15
//   r : next C/D value (both 28-bit halves rotated right by s[i])
//   k : round key PC2(r) used in this round
module key_schedule_inv
  import decrypt_iter_pkg::*;
(
  input  logic [55:0] x,
  input  logic [4:0]  i,
  output logic [55:0] r,
  output logic [47:0] k
);

  logic [1:0] shift;

  assign shift = rotr_amount(i);
  assign r     = {rotr28(x[55:28], shift), rotr28(x[27:0], shift)};
  assign k     = perm_pc2(r);

endmodule

// File: rtl/decrypt_iter.sv
// decrypt_iter: iterative DES decryption, one Feistel round per clock.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : decrypt_iter_if slave (k, c, req in; m, ack out)
// Load on the first req edge, 16 round edges, then ack with m held until
// req drops. Dropping req mid-run aborts without touching m.
module decrypt_iter
  import decrypt_iter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decrypt_iter_if.slave  bus
);

  state_e      state_q;
  logic [4:0]  rnd_q;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [55:0] cd_q;
  logic [63:0] m_q;
  logic        ack_q;

  logic [55:0] cd_d;
  logic [47:0] rkey;
  logic [63:0] lr_d;

  key_schedule_inv u_ks (
    .x (cd_q),
    .i (rnd_q),
    .r (cd_d),
    .k (rkey)
  );

  assign lr_d    = des_round(l_q, r_q, rkey);
  assign bus.m   = m_q;
  assign bus.ack = ack_q;

  // Control FSM and datapath registers. The final round also applies the
  // closing swap (R16, L16) and FP before registering the plaintext.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      m_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            {l_q, r_q} <= perm_ip(bus.c);
            cd_q       <= perm_pc1(bus.k);
            rnd_q      <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (!bus.req) begin
            state_q <= IDLE;
          end else begin
            l_q   <= lr_d[63:32];
            r_q   <= lr_d[31:0];
            cd_q  <= cd_d;
            rnd_q <= rnd_q + 5'd1;
            if (rnd_q == 5'(N_R - 1)) begin
              m_q     <= perm_fp({lr_d[31:0], lr_d[63:32]});
              ack_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.req) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
